// File: rtl/mux4_arbiter_if.sv
// Bus bundle between four requesters and the mux4 arbiter.
// master = requester side, slave = arbiter side.
interface mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       z;
  logic       valid;

  modport master (output req, output d, input gnt, input sel, input z, input valid);
  modport slave  (input req, input d, output gnt, output sel, output z, output valid);
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter with bounded hold time, steering one of four data bits
// through a mux4 selected by the registered owner index.
module mux4 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       z
);
  always_comb begin
    z = d0;
    case (sel)
      2'd0: z = d0;
      2'd1: z = d1;
      2'd2: z = d2;
      2'd3: z = d3;
      default: z = d0;
    endcase
  end
endmodule

module mux4_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic           clk,
  input logic           rst,
  mux4_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sel_reg, sel_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      gnt_reg, gnt_next;
  logic            valid_reg, valid_next;

  logic [3:0]      own_mask;
  logic [3:0]      cand;
  logic [3:0]      rot_req;
  logic            found;
  logic [1:0]      win_ofs;
  logic [1:0]      winner;

  // The current owner is excluded from candidates so a re-arbitration in BUSY
  // always moves the grant to someone else.
  assign own_mask = 4'b0001 << sel_reg;
  assign cand     = (state_reg == BUSY) ? (bus.req & ~own_mask) : bus.req;

  // rot_req[k] is the candidate k positions after the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFS = 2'(gi);
      assign rot_req[gi] = cand[ptr_reg + OFS];
    end
  endgenerate

  always_comb begin
    found   = 1'b0;
    win_ofs = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) begin
        found   = 1'b1;
        win_ofs = 2'(i);
      end
    end
  end

  assign winner = ptr_reg + win_ofs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      ptr_reg   <= 2'd0;
      cnt_reg   <= '0;
      gnt_reg   <= 4'b0000;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          sel_next   = winner;
          ptr_next   = winner + 2'd1;
          cnt_next   = CW'(1);
        end
      end
      BUSY: begin
        if (!bus.req[sel_reg] || (cnt_reg >= CW'(MAX_HOLD))) begin
          if (found) begin
            sel_next = winner;
            ptr_next = winner + 2'd1;
            cnt_next = CW'(1);
          end else if (!bus.req[sel_reg]) begin
            state_next = IDLE;
          end
          // otherwise the owner is the sole requester and cnt stays saturated
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    gnt_next   = (state_next == BUSY) ? (4'b0001 << sel_next) : 4'b0000;
    valid_next = (state_next == BUSY);
  end

  assign bus.gnt   = gnt_reg;
  assign bus.sel   = sel_reg;
  assign bus.valid = valid_reg;

  mux4 u_mux4 (
    .d0  (bus.d[0]),
    .d1  (bus.d[1]),
    .d2  (bus.d[2]),
    .d3  (bus.d[3]),
    .sel (sel_reg),
    .z   (bus.z)
  );
endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter (MAX_HOLD = 4) with a per-cycle invariant monitor.
module tb_mux4_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  mux4_arbiter_if bus ();

  mux4_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b req=%b d=%b gnt=%b sel=%0d valid=%b z=%b",
             $time, rst, bus.req, bus.d, bus.gnt, bus.sel, bus.valid, bus.z);
  endtask

  // Invariants sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      check("valid_eq_or_gnt", 32'(bus.valid), 32'(|bus.gnt));
      check("z_eq_d_sel", 32'(bus.z), 32'(bus.d[bus.sel]));
    end
  end

  initial begin
    int owner;
    int exp_cnt;

    bus.req = 4'b0000;
    bus.d   = 4'b0000;

    // Reset state
    tick();
    tick();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    check("release_no_grant", 32'(bus.gnt), 32'h0);

    // Single-edge request 1010 -> requester 1 wins from ptr 0
    bus.req = 4'b1010;
    bus.d   = 4'b0010;
    tick();
    check("first_gnt", 32'(bus.gnt), 32'h2);
    check("first_sel", 32'(bus.sel), 32'h1);
    check("first_valid", 32'(bus.valid), 32'h1);
    check("first_z", 32'(bus.z), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("idle_gnt", 32'(bus.gnt), 32'h0);
    check("idle_valid", 32'(bus.valid), 32'h0);
    check("idle_sel_hold", 32'(bus.sel), 32'h1);

    // All four requesting: 4 cycles each, order 0,1,2,3,0, no gaps
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.d   = 4'b0101;
    for (int k = 0; k < 20; k++) begin
      tick();
      owner = (k / 4) % 4;
      check("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << owner));
      check("rr_z", 32'(bus.z), 32'(owner % 2 == 0));
    end

    // Owner 2, then only requester 0 -> handover with no gap, then idle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b0100;
    tick();
    check("own2_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0001;
    tick();
    check("handover_gnt", 32'(bus.gnt), 32'h1);
    check("handover_sel", 32'(bus.sel), 32'h0);
    check("handover_cnt", 32'(dut.cnt_reg), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("drop_gnt", 32'(bus.gnt), 32'h0);
    check("drop_valid", 32'(bus.valid), 32'h0);
    check("drop_sel", 32'(bus.sel), 32'h0);

    // Sole requester 3 for 20 cycles: grant steady, cnt saturates at 4
    bus.req = 4'b1000;
    bus.d   = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_cnt = (k + 1 < 4) ? k + 1 : 4;
      check("sole_gnt", 32'(bus.gnt), 32'h8);
      check("sole_cnt", 32'(dut.cnt_reg), 32'(exp_cnt));
    end

    // Asynchronous reset while requester 2 owns the mux
    bus.req = 4'b0100;
    tick();
    check("pre_rst_gnt", 32'(bus.gnt), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(bus.gnt), 32'h0);
    check("async_rst_sel", 32'(bus.sel), 32'h0);
    check("async_rst_valid", 32'(bus.valid), 32'h0);
    tick();
    rst = 1'b0;
    bus.req = 4'b1100;
    bus.d   = 4'b0100;
    tick();
    check("post_rst_gnt", 32'(bus.gnt), 32'h4);
    check("post_rst_sel", 32'(bus.sel), 32'h2);
    check("post_rst_z", 32'(bus.z), 32'h1);

    bus.req = 4'b0000;
    tick();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001: Parameter MAX_HOLD, default 4, sets the maximum consecutive grant cycles per owner while another requester waits; legal range 2..15.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: req  input  4  request per requester; req[i] high = requester i wants the mux.
REQ-005: d  input  4  data bit per requester; d[i] belongs to requester i.
REQ-006: gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-007: sel  output  2  registered index of current or last owner; drives the mux4 select.
REQ-008: z  output  1  d[sel], produced by one internal mux4 instance (d0..d3 = d[0]..d[3], sel = sel).
REQ-009: valid  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-010: The block shall implement two states: IDLE (no owner) and BUSY (one owner, gnt = one-hot of sel).
REQ-011: The block shall keep a 2-bit round-robin pointer ptr = (last owner + 1) mod 4 and a hold counter cnt of width ceil(log2(MAX_HOLD+1)).
REQ-012: Arbitration shall pick the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013: IDLE, req != 0 at edge: next state BUSY, sel = winner, gnt = one-hot(winner), cnt = 1, ptr = winner+1; grant latency is exactly one cycle.
REQ-014: IDLE, req == 0: remain IDLE; gnt = 0, sel unchanged.
REQ-015: BUSY, req[sel]=0 and some other req high: re-arbitrate at that edge (search from sel+1); new owner granted the next cycle with no idle gap; cnt = 1.
REQ-016: BUSY, req[sel]=0 and no req high: go IDLE; gnt = 0, valid = 0; sel holds the last owner.
REQ-017: BUSY, req[sel]=1 and cnt < MAX_HOLD: keep owner; cnt increments.
REQ-018: BUSY, req[sel]=1, cnt == MAX_HOLD, another req high: pre-empt; grant passes to next requester in round-robin order after sel; cnt = 1.
REQ-019: BUSY, req[sel]=1, cnt == MAX_HOLD, no other req: keep owner; cnt saturates at MAX_HOLD (no wrap).
REQ-020: The owner itself shall never be selected by a re-arbitration in REQ-015/REQ-018 unless it is the sole requester when re-arbitration is evaluated via REQ-013.
REQ-021: gnt shall never have more than one bit set; sel and gnt shall change on the same edge.
REQ-022: z shall be combinational from d and registered sel: zero added latency from d to z.

Reset
REQ-023: While rst=1 (asynchronously on assertion): state IDLE, gnt = 4'b0000, sel = 2'b00, valid = 0, ptr = 0, cnt = 0.
REQ-024: Reset asserted mid-grant shall drop gnt/valid immediately without waiting for clk; first grant after release uses ptr = 0 (requester 0 highest).
REQ-025: Release of rst shall take effect only at the next rising clk edge; no grant issued on the release edge itself unless req sampled high on it.

Verification
REQ-026: Reset, then req=4'b1010 for one edge -> next cycle gnt=4'b0010, sel=1, valid=1; with d=4'b0010, z=1.
REQ-027: req=4'b1111 held constantly, MAX_HOLD=4 -> owner sequence 0,1,2,3,0 with each owner granted exactly 4 cycles, no idle cycle between owners.
REQ-028: Owner 2 granted, req drops to 4'b0001 -> next cycle gnt=4'b0001, sel=0, cnt=1; then req=0 -> gnt=0, valid=0, sel stays 0.
REQ-029: Only req[3] held for 20 cycles -> gnt=4'b1000 throughout, cnt saturates at 4, no glitch to other grants.
REQ-030: rst asserted mid-cycle while gnt=4'b0100 -> gnt=0, sel=0, valid=0 before next clk edge; after release with req=4'b1100 -> gnt=4'b0100 (ptr restarted at 0).
REQ-031: Throughout all scenarios, a checker shall assert $onehot0(gnt), valid == |gnt, and z == d[sel] every cycle.
